// File: rtl/uart_baud_gen_frac.sv
// Fractional-N UART baud generator.
// Produces an oversampled sample tick and a 1x baud tick from a run-time loadable
// integer.fraction divisor. The phase can be resynchronised to a start-bit edge.
module uart_baud_gen_frac #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned FRAC_BITS  = 4
) (
  input  logic                          iClk,
  input  logic                          iRst,
  input  logic                          iEnable,
  input  logic [DIV_WIDTH-1:0]          iDiv_int,
  input  logic [FRAC_BITS-1:0]          iDiv_frac,
  input  logic                          iDiv_load,
  input  logic                          iResync,
  output logic                          oSample_tick,
  output logic                          oBaud_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] oPhase,
  output logic                          oLoad_pending
);

  localparam int unsigned PhW  = $clog2(OVERSAMPLE);
  localparam int unsigned DivW = DIV_WIDTH + FRAC_BITS;

  // Reset-default divisor in 1/2^FRAC_BITS clock units, rounded to nearest.
  localparam longint unsigned DefNum = longint'(CLK_FREQ) << FRAC_BITS;
  localparam longint unsigned DefDen = longint'(BAUD_RATE) * longint'(OVERSAMPLE);
  localparam longint unsigned DefDiv = (64'd2 * DefNum + DefDen) / (64'd2 * DefDen);

  localparam logic [DivW-1:0]      DefFull   = DivW'(DefDiv);
  localparam logic [DIV_WIDTH-1:0] DefInt    = DefFull[DivW-1:FRAC_BITS];
  localparam logic [FRAC_BITS-1:0] DefFrac   = DefFull[FRAC_BITS-1:0];
  localparam logic [PhW-1:0]       PhaseLast = PhW'(OVERSAMPLE - 1);
  localparam logic [PhW-1:0]       PhaseMid  = PhW'(OVERSAMPLE / 2);
  localparam logic [DIV_WIDTH-1:0] MinInt    = DIV_WIDTH'(2);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [FRAC_BITS-1:0] acc_q, acc_d;
  logic [PhW-1:0]       phase_q, phase_d;
  logic [DIV_WIDTH-1:0] int_q, int_d;
  logic [FRAC_BITS-1:0] frac_q, frac_d;
  logic [DIV_WIDTH-1:0] pend_int_q, pend_int_d;
  logic [FRAC_BITS-1:0] pend_frac_q, pend_frac_d;
  logic                 pend_q, pend_d;
  logic                 sample_q, sample_d;
  logic                 baud_q, baud_d;

  logic [DIV_WIDTH-1:0] eff_int;
  logic [FRAC_BITS:0]   frac_sum;
  logic [DIV_WIDTH:0]   period_m1;
  logic                 wrap;
  logic                 apply;

  // Period of the current sample interval. The carry comes straight from the
  // accumulator sum, so the extra clock lands in the period whose fraction overflows.
  always_comb begin
    eff_int   = (int_q < MinInt) ? MinInt : int_q;
    frac_sum  = {1'b0, acc_q} + {1'b0, frac_q};
    period_m1 = {1'b0, eff_int} + {{DIV_WIDTH{1'b0}}, frac_sum[FRAC_BITS]}
                - {{DIV_WIDTH{1'b0}}, 1'b1};
    // >= rather than == keeps the counter sane if a smaller divisor is applied
    // while disabled with the count already past the new terminal value.
    wrap      = iEnable && !iResync && ({1'b0, cnt_q} >= period_m1);
    apply     = pend_q && (wrap || !iEnable || iResync);
  end

  // Next-state for counter, fraction accumulator, phase, ticks and divisor.
  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    phase_d     = phase_q;
    int_d       = int_q;
    frac_d      = frac_q;
    pend_int_d  = pend_int_q;
    pend_frac_d = pend_frac_q;
    pend_d      = pend_q;
    sample_d    = 1'b0;
    baud_d      = 1'b0;

    if (iResync) begin
      cnt_d   = '0;
      acc_d   = '0;
      phase_d = PhaseMid;
    end else if (iEnable) begin
      if (wrap) begin
        cnt_d    = '0;
        acc_d    = frac_sum[FRAC_BITS-1:0];
        sample_d = 1'b1;
        if (phase_q == PhaseLast) begin
          baud_d  = 1'b1;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PhW'(1);
        end
      end else begin
        cnt_d = cnt_q + DIV_WIDTH'(1);
      end
    end

    if (apply) begin
      int_d  = pend_int_q;
      frac_d = pend_frac_q;
      acc_d  = '0;
    end

    // A fresh load always wins, so back-to-back loads keep the last one.
    if (iDiv_load) begin
      pend_int_d  = iDiv_int;
      pend_frac_d = iDiv_frac;
      pend_d      = 1'b1;
    end else if (apply) begin
      pend_d = 1'b0;
    end
  end

  // State registers; reset restores the default divisor and drops any pending load.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      phase_q     <= '0;
      int_q       <= DefInt;
      frac_q      <= DefFrac;
      pend_int_q  <= '0;
      pend_frac_q <= '0;
      pend_q      <= 1'b0;
      sample_q    <= 1'b0;
      baud_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      phase_q     <= phase_d;
      int_q       <= int_d;
      frac_q      <= frac_d;
      pend_int_q  <= pend_int_d;
      pend_frac_q <= pend_frac_d;
      pend_q      <= pend_d;
      sample_q    <= sample_d;
      baud_q      <= baud_d;
    end
  end

  assign oSample_tick  = sample_q;
  assign oBaud_tick    = baud_q;
  assign oPhase        = phase_q;
  assign oLoad_pending = pend_q;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Directed bench for uart_baud_gen_frac with default parameters
// (DEF = 5208 -> int 325, frac 8; OVERSAMPLE 16).
module tb_uart_baud_gen_frac;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] div_int = '0;
  logic [3:0]  div_frac = '0;
  logic        div_load = 1'b0;
  logic        resync = 1'b0;
  logic        sample_tick;
  logic        baud_tick;
  logic [3:0]  phase;
  logic        load_pending;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  uart_baud_gen_frac dut (
    .iClk          (clk),
    .iRst          (rst_n),
    .iEnable       (enable),
    .iDiv_int      (div_int),
    .iDiv_frac     (div_frac),
    .iDiv_load     (div_load),
    .iResync       (resync),
    .oSample_tick  (sample_tick),
    .oBaud_tick    (baud_tick),
    .oPhase        (phase),
    .oLoad_pending (load_pending)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Returns the cycle stamp of the next sample tick, seen on a falling edge.
  task automatic wait_sample(input string tag, output int t);
    int n = 0;
    t = -1;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_tick && n < 1000);
    if (sample_tick) t = cyc;
    else check_eq({tag, " timeout"}, 32'(sample_tick), 32'd1);
  endtask

  task automatic wait_baud(input string tag, output int t);
    int n = 0;
    t = -1;
    do begin
      @(negedge clk);
      n++;
    end while (!baud_tick && n < 12000);
    if (baud_tick) t = cyc;
    else check_eq({tag, " timeout"}, 32'(baud_tick), 32'd1);
  endtask

  task automatic load_div(input logic [15:0] i, input logic [3:0] f);
    div_int  = i;
    div_frac = f;
    div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
  endtask

  int rel, t0, t1, t2, b1, b2, r, ticks, hops;
  int frac_exp [4] = '{10, 10, 10, 11};

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst sample", 32'(sample_tick), 32'd0);
    check_eq("rst baud", 32'(baud_tick), 32'd0);
    check_eq("rst phase", 32'(phase), 32'd0);
    check_eq("rst pending", 32'(load_pending), 32'd0);

    // Default divisor: ticks at 325, 651, 976; baud at 5208, then every 5208
    rst_n  = 1'b1;
    enable = 1'b1;
    rel    = cyc;
    wait_sample("def t1", t0);
    check_eq("def tick1 edge", 32'(t0 - rel), 32'd325);
    check_eq("def tick1 phase", 32'(phase), 32'd1);
    wait_sample("def t2", t0);
    check_eq("def tick2 edge", 32'(t0 - rel), 32'd651);
    wait_sample("def t3", t0);
    check_eq("def tick3 edge", 32'(t0 - rel), 32'd976);
    check_eq("def tick3 phase", 32'(phase), 32'd3);
    wait_baud("def b1", b1);
    check_eq("def baud1 edge", 32'(b1 - rel), 32'd5208);
    check_eq("baud with sample", 32'(sample_tick), 32'd1);
    check_eq("baud phase", 32'(phase), 32'd0);
    wait_baud("def b2", b2);
    check_eq("def baud spacing", 32'(b2 - b1), 32'd5208);

    // Integer divisor 10
    load_div(16'd10, 4'd0);
    check_eq("int pending set", 32'(load_pending), 32'd1);
    wait_sample("int apply", t0);
    check_eq("int pending clr", 32'(load_pending), 32'd0);
    wait_sample("int t1", t1);
    check_eq("int period1", 32'(t1 - t0), 32'd10);
    wait_sample("int t2", t2);
    check_eq("int period2", 32'(t2 - t1), 32'd10);
    wait_baud("int b1", b1);
    wait_baud("int b2", b2);
    check_eq("int baud spacing", 32'(b2 - b1), 32'd160);

    // Fractional 10 + 4/16: 10,10,10,11 repeating, baud every 164
    load_div(16'd10, 4'd4);
    wait_sample("frac apply", t0);
    for (int i = 0; i < 4; i++) begin
      wait_sample("frac tk", t1);
      check_eq($sformatf("frac period%0d", i), 32'(t1 - t0), 32'(frac_exp[i]));
      t0 = t1;
    end
    wait_baud("frac b1", b1);
    wait_baud("frac b2", b2);
    check_eq("frac baud spacing", 32'(b2 - b1), 32'd164);

    // Resync at phase 3, landing on the terminal count so the tick is suppressed
    load_div(16'd10, 4'd0);
    wait_sample("rs apply", t0);
    hops = 0;
    while (phase != 4'd3 && hops < 20) begin
      wait_sample("rs seek", t0);
      hops++;
    end
    check_eq("rs at phase3", 32'(phase), 32'd3);
    repeat (9) @(negedge clk);
    resync = 1'b1;
    @(negedge clk);
    resync = 1'b0;
    r = cyc;
    check_eq("rs no sample", 32'(sample_tick), 32'd0);
    check_eq("rs no baud", 32'(baud_tick), 32'd0);
    check_eq("rs phase", 32'(phase), 32'd8);
    wait_sample("rs t1", t1);
    check_eq("rs first tick", 32'(t1 - r), 32'd10);
    check_eq("rs first phase", 32'(phase), 32'd9);
    wait_baud("rs b1", b1);
    check_eq("rs first baud", 32'(b1 - r), 32'd80);
    wait_baud("rs b2", b2);
    check_eq("rs baud spacing", 32'(b2 - b1), 32'd160);

    // Async reset mid-bit with a pending load: outputs clear at once, pending dropped
    wait_sample("ar pre", t0);
    load_div(16'd20, 4'd0);
    check_eq("ar pending pre", 32'(load_pending), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("ar sample", 32'(sample_tick), 32'd0);
    check_eq("ar baud", 32'(baud_tick), 32'd0);
    check_eq("ar phase", 32'(phase), 32'd0);
    check_eq("ar pending", 32'(load_pending), 32'd0);

    // Enable gating at cnt=100 for 50 cycles on the restored default divisor
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    enable = 1'b0;
    ticks = 0;
    repeat (50) begin
      @(negedge clk);
      if (sample_tick || baud_tick) ticks++;
    end
    check_eq("gate no ticks", 32'(ticks), 32'd0);
    enable = 1'b1;
    r = cyc;
    wait_sample("gate t1", t1);
    check_eq("gate resume", 32'(t1 - r), 32'd225);
    check_eq("gate phase", 32'(phase), 32'd1);

    // Clamp: int 1 and int 0 both give a 2-clock period
    load_div(16'd1, 4'd0);
    wait_sample("c1 apply", t0);
    wait_sample("c1 t1", t1);
    check_eq("clamp1 period", 32'(t1 - t0), 32'd2);
    wait_sample("c1 t2", t2);
    check_eq("clamp1 period2", 32'(t2 - t1), 32'd2);
    load_div(16'd0, 4'd0);
    wait_sample("c0 apply", t0);
    wait_sample("c0 t1", t1);
    check_eq("clamp0 period", 32'(t1 - t0), 32'd2);

    // Load while disabled applies on the following edge
    enable = 1'b0;
    load_div(16'd7, 4'd0);
    check_eq("dis pending set", 32'(load_pending), 32'd1);
    check_eq("dis no tick", 32'(sample_tick), 32'd0);
    @(negedge clk);
    check_eq("dis pending clr", 32'(load_pending), 32'd0);
    enable = 1'b1;
    wait_sample("dis t0", t0);
    wait_sample("dis t1", t1);
    check_eq("dis new period", 32'(t1 - t0), 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
